// File: rtl/disp_mode_ctrl.sv
// Display mode controller: selects the active display mode through a SELECT
// menu driven by debounced buttons, and routes the matching time source to the display.
module disp_mode_ctrl #(
    parameter int TIMEOUT = 10
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_ok,
    input  logic        tick_1hz,
    input  logic [19:0] clock_time,
    input  logic [19:0] set_time,
    input  logic [19:0] alarm_time,
    input  logic [19:0] count_time,
    output logic [5:0]  state_info,
    output logic [19:0] time_data,
    output logic        set_en,
    output logic        alarm_en,
    output logic        count_en,
    output logic        mode_chg
);

    localparam logic [2:0] M_IDLE   = 3'b000;
    localparam logic [2:0] M_SET    = 3'b001;
    localparam logic [2:0] M_ALARM  = 3'b010;
    localparam logic [2:0] M_COUNT  = 3'b011;
    localparam logic [2:0] M_SELECT = 3'b100;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    mode_q, mode_d;
    logic [2:0]    cand_q, cand_d;
    logic [2:0]    prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chg_d;
    logic [19:0]   time_q, time_d;
    logic          set_en_q, alarm_en_q, count_en_q, mode_chg_q;

    // Button priority inside SELECT is ok > mode > next; a tick only counts
    // in cycles with no button at all.
    always_comb begin
        mode_d = mode_q;
        cand_d = cand_q;
        prev_d = prev_q;
        cnt_d  = cnt_q;
        chg_d  = 1'b0;
        if (mode_q > M_SELECT) begin
            mode_d = M_IDLE;
            cand_d = M_IDLE;
        end else if (mode_q != M_SELECT) begin
            if (btn_mode) begin
                mode_d = M_SELECT;
                prev_d = mode_q;
                cand_d = mode_q;
                cnt_d  = '0;
            end
        end else if (btn_ok) begin
            mode_d = cand_q;
            chg_d  = (cand_q != prev_q);
            cnt_d  = '0;
        end else if (btn_mode) begin
            mode_d = prev_q;
            cnt_d  = '0;
        end else if (btn_next) begin
            cand_d = (cand_q == M_COUNT) ? M_IDLE : cand_q + 3'd1;
            cnt_d  = '0;
        end else if (tick_1hz) begin
            if (cnt_q == CNT_LAST) begin
                mode_d = prev_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        time_d = time_q;
        case (mode_q)
            M_IDLE:  time_d = clock_time;
            M_SET:   time_d = set_time;
            M_ALARM: time_d = alarm_time;
            M_COUNT: time_d = count_time;
            default: time_d = time_q;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            mode_q     <= M_IDLE;
            cand_q     <= M_IDLE;
            prev_q     <= M_IDLE;
            cnt_q      <= '0;
            time_q     <= 20'h0;
            set_en_q   <= 1'b0;
            alarm_en_q <= 1'b0;
            count_en_q <= 1'b0;
            mode_chg_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            cand_q     <= cand_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            time_q     <= time_d;
            set_en_q   <= (mode_d == M_SET);
            alarm_en_q <= (mode_d == M_ALARM);
            count_en_q <= (mode_d == M_COUNT);
            mode_chg_q <= chg_d;
        end
    end

    assign state_info = {cand_q, mode_q};
    assign time_data  = time_q;
    assign set_en     = set_en_q;
    assign alarm_en   = alarm_en_q;
    assign count_en   = count_en_q;
    assign mode_chg   = mode_chg_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Bench for disp_mode_ctrl: directed scenarios then random button/tick traffic,
// all compared against a behavioural model of the mode menu.
module tb_disp_mode_ctrl;

    localparam int TIMEOUT = 10;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        btn_mode, btn_next, btn_ok, tick_1hz;
    logic [19:0] clock_time, set_time, alarm_time, count_time;
    logic [5:0]  state_info;
    logic [19:0] time_data;
    logic        set_en, alarm_en, count_en, mode_chg;

    int n_checks = 0;
    int n_err    = 0;

    // model state: modes 0..3 are IDLE/SET/ALARM/COUNT, 4 is SELECT
    int          m_mode, m_cand, m_prev, m_ticks;
    logic        m_chg;
    logic [19:0] m_time;

    disp_mode_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_ok(btn_ok), .tick_1hz(tick_1hz),
        .clock_time(clock_time), .set_time(set_time),
        .alarm_time(alarm_time), .count_time(count_time),
        .state_info(state_info), .time_data(time_data),
        .set_en(set_en), .alarm_en(alarm_en), .count_en(count_en), .mode_chg(mode_chg)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cand = 0; m_prev = 0; m_ticks = 0; m_chg = 1'b0; m_time = 20'h0;
    endtask

    function automatic logic [19:0] src_of(input int m);
        case (m)
            0: return clock_time;
            1: return set_time;
            2: return alarm_time;
            default: return count_time;
        endcase
    endfunction

    task automatic model_step();
        int old_mode;
        old_mode = m_mode;
        m_chg = 1'b0;
        if (m_mode != 4) begin
            if (btn_mode) begin
                m_prev = m_mode; m_cand = m_mode; m_mode = 4; m_ticks = 0;
            end
        end else if (btn_ok) begin
            m_chg = (m_cand != m_prev); m_mode = m_cand; m_ticks = 0;
        end else if (btn_mode) begin
            m_mode = m_prev; m_ticks = 0;
        end else if (btn_next) begin
            m_cand = (m_cand + 1) % 4; m_ticks = 0;
        end else if (tick_1hz) begin
            m_ticks++;
            if (m_ticks == TIMEOUT) begin
                m_mode = m_prev; m_ticks = 0;
            end
        end
        if (old_mode != 4) m_time = src_of(old_mode);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state_info"}, 32'(state_info), 32'({3'(m_cand), 3'(m_mode)}));
        check({tag, ".time_data"},  32'(time_data),  32'(m_time));
        check({tag, ".set_en"},     32'(set_en),     32'(m_mode == 1));
        check({tag, ".alarm_en"},   32'(alarm_en),   32'(m_mode == 2));
        check({tag, ".count_en"},   32'(count_en),   32'(m_mode == 3));
        check({tag, ".mode_chg"},   32'(mode_chg),   32'(m_chg));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".state_info"}, 32'(state_info), 32'h0);
        check({tag, ".time_data"},  32'(time_data),  32'h0);
        check({tag, ".enables"},    32'({set_en, alarm_en, count_en}), 32'h0);
        check({tag, ".mode_chg"},   32'(mode_chg),   32'h0);
    endtask

    task automatic press(input string tag, input logic bm, input logic bn,
                         input logic bo, input logic tk);
        btn_mode = bm; btn_next = bn; btn_ok = bo; tick_1hz = tk;
        @(posedge clk_sys);
        model_step();
        #1;
        check_all(tag);
        btn_mode = 1'b0; btn_next = 1'b0; btn_ok = 1'b0; tick_1hz = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0; btn_next = 1'b0; btn_ok = 1'b0; tick_1hz = 1'b0;
        clock_time = 20'h4A5B7; set_time = 20'h12345;
        alarm_time = 20'h06300; count_time = 20'h00159;
        model_reset();
        #17;
        check_zero("reset_hold");
        @(negedge clk_sys);
        rst = 1'b0;

        // first edges out of reset show clock_time
        press("post_reset", 0, 0, 0, 0);
        check("post_reset.lit_time", 32'(time_data), 32'h4A5B7);
        check("post_reset.lit_si", 32'(state_info), 32'h0);

        // IDLE -> SELECT -> cand ALARM -> commit
        press("sel_enter", 1, 0, 0, 0);
        check("sel_enter.lit", 32'(state_info), 32'b000100);
        press("sel_next1", 0, 1, 0, 0);
        check("sel_next1.lit", 32'(state_info), 32'b001100);
        press("sel_next2", 0, 1, 0, 0);
        check("sel_next2.lit", 32'(state_info), 32'b010100);
        press("sel_ok", 0, 0, 1, 0);
        check("sel_ok.lit_si", 32'(state_info), 32'b010010);
        check("sel_ok.lit_chg", 32'(mode_chg), 32'h1);
        check("sel_ok.lit_alarm_en", 32'(alarm_en), 32'h1);
        press("alarm_idle", 0, 0, 0, 0);
        check("alarm_idle.lit_chg", 32'(mode_chg), 32'h0);
        check("alarm_idle.lit_time", 32'(time_data), 32'(alarm_time));
        press("ignore_next_ok", 0, 1, 1, 1);

        // ALARM -> SET, then SET -> ALARM -> COUNT -> IDLE with wrap
        press("to_set_m", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) press("to_set_n", 0, 1, 0, 0);
        press("to_set_ok", 0, 0, 1, 0);
        press("set_m", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) press("set_wrap_n", 0, 1, 0, 0);
        press("set_wrap_ok", 0, 0, 1, 0);
        check("set_wrap.lit_mode", 32'(state_info[2:0]), 32'h0);
        check("set_wrap.lit_chg", 32'(mode_chg), 32'h1);
        check("set_wrap.lit_set_en", 32'(set_en), 32'h0);

        // reach COUNT, then timeout behaviour
        press("to_cnt_m", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) press("to_cnt_n", 0, 1, 0, 0);
        press("to_cnt_ok", 0, 0, 1, 0);
        press("to_sel", 1, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) press("tick9", 0, 0, 0, 1);
        check("tick9.lit_sel", 32'(state_info[2:0]), 32'h4);
        press("tick9_next", 0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) press("tick9b", 0, 0, 0, 1);
        check("tick9b.lit_sel", 32'(state_info[2:0]), 32'h4);
        press("tick10", 0, 0, 0, 1);
        check("tick10.lit_mode", 32'(state_info[2:0]), 32'h3);
        check("tick10.lit_count_en", 32'(count_en), 32'h1);
        check("tick10.lit_chg", 32'(mode_chg), 32'h0);

        // coincident buttons: ok beats mode; next beats tick and clears the counter
        press("prio_m", 1, 0, 0, 0);
        press("prio_n", 0, 1, 0, 0);
        press("prio_ok_mode", 1, 0, 1, 0);
        check("prio_ok_mode.lit_mode", 32'(state_info[2:0]), 32'h0);
        check("prio_ok_mode.lit_chg", 32'(mode_chg), 32'h1);
        press("prio2_m", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) press("prio2_tick", 0, 0, 0, 1);
        press("prio2_next_tick", 0, 1, 0, 1);
        check("prio2_next_tick.lit_si", 32'(state_info), 32'b001100);
        for (int i = 0; i < TIMEOUT - 1; i++) press("prio2_tick9", 0, 0, 0, 1);
        check("prio2_tick9.lit_sel", 32'(state_info[2:0]), 32'h4);
        press("prio2_tick10", 0, 0, 0, 1);
        press("prio_all", 0, 0, 0, 0);

        // asynchronous reset in the middle of SELECT with cand = COUNT
        press("rst_m", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) press("rst_n", 0, 1, 0, 0);
        check("rst_pre.lit_si", 32'(state_info), 32'b011100);
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk_sys);
        #1 check_zero("rst_edge");
        #2 rst = 1'b0;
        model_reset();
        press("rst_after", 0, 0, 0, 0);
        check("rst_after.lit_chg", 32'(mode_chg), 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            clock_time = 20'($urandom); set_time = 20'($urandom);
            alarm_time = 20'($urandom); count_time = 20'($urandom);
            press("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
